serial_adder: RTL and testbench

//  Parametrised multi-cycle adder: adds two WIDTH-bit operands plus carry-in,

---
 rtl/serial_adder.sv | 90 +++++++++
 tb/tb_serial_adder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder summing DIGIT bits per clock, LSB digit first, with valid/ready operand and result handshakes
module serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);
  localparam int N = WIDTH / DIGIT;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || WIDTH % DIGIT != 0) begin : g_bad
    $error("serial_adder: invalid WIDTH/DIGIT combination");
  end
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic c_q, c_d, co_q, co_d, ovf_q, ovf_d;
  logic [DIGIT:0] dsum;
  logic [WIDTH+DIGIT-1:0] s_cat;
  logic last, msb_cin;
  assign dsum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, c_q};
  assign msb_cin = dsum[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
  assign s_cat = {dsum[DIGIT-1:0], s_q};
  assign last = cnt_q == CW'(N - 1);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    a_d = a_q;
    b_d = b_q;
    s_d = s_q;
    c_d = c_q;
    co_d = co_q;
    ovf_d = ovf_q;
    if (state_q == IDLE && in_valid) begin
      a_d = a;
      b_d = b;
      c_d = ci;
      cnt_d = '0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      s_d = s_cat[WIDTH+DIGIT-1:DIGIT];
      a_d = a_q >> DIGIT;
      b_d = b_q >> DIGIT;
      c_d = dsum[DIGIT];
      cnt_d = last ? '0 : cnt_q + CW'(1);
      co_d = last ? dsum[DIGIT] : co_q;
      ovf_d = last ? msb_cin ^ dsum[DIGIT] : ovf_q;
      state_d = last ? DONE : RUN;
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
      c_q <= 1'b0;
      co_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      s_q <= s_d;
      c_q <= c_d;
      co_q <= co_d;
      ovf_q <= ovf_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign s = s_q;
  assign co = co_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench running WIDTH=8 adders with DIGIT 1, 2 and 8 side by side
module tb_serial_adder;
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [9:0] e;
  } vec_t;
  localparam vec_t VECS [9] = '{
    '{8'hFF, 8'h01, 1'b0, 10'h200},
    '{8'h7F, 8'h01, 1'b0, 10'h180},
    '{8'h80, 8'h80, 1'b1, 10'h301},
    '{8'hAA, 8'h55, 1'b1, 10'h200},
    '{8'h12, 8'h34, 1'b0, 10'h046},
    '{8'h00, 8'h00, 1'b1, 10'h001},
    '{8'hFF, 8'hFF, 1'b1, 10'h2FF},
    '{8'h40, 8'h40, 1'b0, 10'h180},
    '{8'hC0, 8'h80, 1'b0, 10'h340}
  };
  localparam int NR = 150;
  logic clk = 1'b0;
  int pass = 0;
  int total = 0;
  int fin = 0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  for (genvar i = 0; i < 3; i++) begin : g
    localparam int D = i == 0 ? 1 : i == 1 ? 2 : 8;
    localparam int N = 8 / D;
    logic reset, in_valid, in_ready, out_valid, out_ready, ci, co, ovf;
    logic [7:0] a, b, s;
    logic [9:0] q [$];
    serial_adder #(.WIDTH(8), .DIGIT(D)) dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .a(a),
      .b(b),
      .ci(ci),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .s(s),
      .co(co),
      .ovf(ovf)
    );
    function automatic string nm(input string t);
      return $sformatf("d%0d_%s", D, t);
    endfunction
    always @(negedge clk) begin
      if (out_valid && out_ready) begin
        chk(nm("sb_pending"), int'(q.size() != 0), 1);
        if (q.size() != 0) chk(nm("result"), int'({co, ovf, s}), int'(q.pop_front()));
      end
    end
    task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic c, input logic [9:0] e);
      int n;
      a = x;
      b = y;
      ci = c;
      in_valid = 1'b1;
      q.push_back(e);
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
        n++;
        @(negedge clk);
      end
      chk(nm("accept"), int'(in_ready), 1);
      step();
      in_valid = 1'b0;
      a = ~x;
      b = ~y;
      ci = ~c;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < N + 10) begin
        chk(nm("busy_in_ready"), int'(in_ready), 0);
        n++;
        @(negedge clk);
      end
      chk(nm("latency"), n, N);
    endtask
    initial begin
      logic [7:0] ra, rb;
      logic rc;
      logic [8:0] sm;
      int sent, guard;
      bit hs;
      reset = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      ci = 1'b0;
      repeat (2) step();
      reset = 1'b0;
      @(negedge clk);
      chk(nm("rst_in_ready"), int'(in_ready), 1);
      chk(nm("rst_out_valid"), int'(out_valid), 0);
      chk(nm("rst_s"), int'(s), 0);
      chk(nm("rst_co"), int'(co), 0);
      chk(nm("rst_ovf"), int'(ovf), 0);
      step();
      out_ready = 1'b1;
      for (int k = 0; k < 9; k++) begin
        issue(VECS[k].a, VECS[k].b, VECS[k].ci, VECS[k].e);
        step();
      end
      out_ready = 1'b0;
      issue(8'h3C, 8'h0F, 1'b0, 10'h04B);
      for (int j = 0; j < 5; j++) begin
        step();
        in_valid = j[0];
        a = 8'hEE;
        @(negedge clk);
        chk(nm("hold_valid"), int'(out_valid), 1);
        chk(nm("hold_s"), int'(s), 8'h4B);
        chk(nm("hold_in_ready"), int'(in_ready), 0);
      end
      step();
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      step();
      @(negedge clk);
      chk(nm("release_in_ready"), int'(in_ready), 1);
      chk(nm("release_out_valid"), int'(out_valid), 0);
      chk(nm("idle_s_held"), int'(s), 8'h4B);
      step();
      a = 8'h55;
      b = 8'h66;
      ci = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      chk(nm("rst_run_accept"), int'(in_ready), 1);
      step();
      in_valid = 1'b0;
      repeat (N - 1 < 3 ? N - 1 : 3) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      chk(nm("midrst_out_valid"), int'(out_valid), 0);
      chk(nm("midrst_in_ready"), int'(in_ready), 1);
      chk(nm("midrst_s"), int'(s), 0);
      chk(nm("midrst_co"), int'(co), 0);
      chk(nm("midrst_ovf"), int'(ovf), 0);
      step();
      issue(8'h12, 8'h34, 1'b0, 10'h046);
      step();
      sent = 0;
      guard = 0;
      while ((sent < NR || q.size() != 0) && guard < 20000) begin
        @(negedge clk);
        hs = in_valid && in_ready;
        step();
        guard++;
        if (hs) begin
          in_valid = 1'b0;
          a = 8'($urandom);
          b = 8'($urandom);
          ci = 1'($urandom);
          sent++;
        end
        if (!in_valid && sent < NR && $urandom_range(0, 2) == 0) begin
          ra = 8'($urandom);
          rb = 8'($urandom);
          rc = 1'($urandom);
          sm = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
          q.push_back({sm[8], (ra[7] == rb[7]) && (sm[7] != ra[7]), sm[7:0]});
          a = ra;
          b = rb;
          ci = rc;
          in_valid = 1'b1;
        end
        out_ready = $urandom_range(0, 3) != 0;
      end
      chk(nm("random_sent"), sent, NR);
      chk(nm("random_drained"), q.size(), 0);
      fin++;
    end
  end
  initial begin
    fork
      wait (fin == 3);
      begin
        #500000;
        $display("FAIL timeout: %0d of 3 lanes finished", fin);
        total++;
      end
    join_any
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
